// File: rtl/signal_flt_mch_if.sv
// Bundle of the per-channel sample, threshold, control and status signals
// of signal_flt_mch. Signal names keep the legacy port names so existing
// connections map one-to-one onto interface members.
interface signal_flt_mch_if #(
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned GCNT_W = 8
);
  // sample inputs
  logic [CH_NUM-1:0]        i_vld;
  logic [CH_NUM-1:0]        i_vld_data;
  // shared run-length thresholds
  logic [CNT_W-1:0]         i_dn_th;
  logic [CNT_W-1:0]         i_up_th;
  // per-channel controls
  logic [CH_NUM-1:0]        i_rtmon;
  logic [CH_NUM-1:0]        i_clr;
  logic [CH_NUM-1:0]        i_sticky_clr;
  // status outputs
  logic [CH_NUM-1:0]        o_flt_sig;
  logic [CH_NUM-1:0]        o_pls_evt;
  logic [CH_NUM-1:0]        o_pls_lvl;
  logic [CH_NUM-1:0]        o_pls_sticky;
  logic [CH_NUM*GCNT_W-1:0] o_glitch_cnt;
  logic                     o_cfg_err;

  // driver side (sample source / register block)
  modport master (
    output i_vld, i_vld_data, i_dn_th, i_up_th, i_rtmon, i_clr, i_sticky_clr,
    input  o_flt_sig, o_pls_evt, o_pls_lvl, o_pls_sticky, o_glitch_cnt, o_cfg_err
  );

  // filter side
  modport slave (
    input  i_vld, i_vld_data, i_dn_th, i_up_th, i_rtmon, i_clr, i_sticky_clr,
    output o_flt_sig, o_pls_evt, o_pls_lvl, o_pls_sticky, o_glitch_cnt, o_cfg_err
  );
endinterface

// File: rtl/signal_flt_mch.sv
// Multi-channel sampled-level filter and pulse-width classifier.
// Each channel tracks the run length of identical valid samples, adopts a
// new filtered level once a run is longer than i_up_th, and reports runs
// whose length falls inside [i_dn_th, i_up_th] as pulse events.
// Optional feature macro: SIGNAL_FLT_MCH_GLITCH_CNT_EN enables the
// per-channel saturating glitch counters; otherwise o_glitch_cnt is 0.
module signal_flt_mch #(
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned GCNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  signal_flt_mch_if.slave      bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // per-channel run state
  logic [CH_NUM-1:0] last_vld_q;
  logic [CH_NUM-1:0] last_data_q;
  logic [CH_NUM-1:0] flt_q;
  logic [CNT_W-1:0]  cnt_q [CH_NUM];

  // registered outputs
  logic [CH_NUM-1:0] flt_sig_q;
  logic [CH_NUM-1:0] evt_q;
  logic [CH_NUM-1:0] lvl_q;
  logic [CH_NUM-1:0] sticky_q;
  logic              cfg_err_q;

  // next-state terms
  logic [CH_NUM-1:0] take;
  logic [CH_NUM-1:0] run_end;
  logic [CH_NUM-1:0] in_win;
  logic [CH_NUM-1:0] evt_d;
  logic [CH_NUM-1:0] adopt;
  logic [CNT_W-1:0]  cnt_d [CH_NUM];

  // Per-channel run tracking: sample acceptance, run end, window test, adoption.
  always_comb begin
    take    = '0;
    run_end = '0;
    in_win  = '0;
    evt_d   = '0;
    adopt   = '0;
    for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
      cnt_d[ch]   = cnt_q[ch];
      // a clear in the same cycle discards the sample
      take[ch]    = bus.i_vld[ch] & ~bus.i_clr[ch];
      run_end[ch] = take[ch] & last_vld_q[ch] &
                    (bus.i_vld_data[ch] != last_data_q[ch]);
      if (take[ch]) begin
        if (!last_vld_q[ch] || run_end[ch]) begin
          cnt_d[ch] = CNT_ONE;
        end else if (cnt_q[ch] != CNT_MAX) begin
          cnt_d[ch] = cnt_q[ch] + CNT_ONE;
        end
      end
      // A saturated counter only means "at least CNT_MAX", so it is never
      // treated as an in-window length even when i_up_th is all-ones.
      in_win[ch] = (cnt_q[ch] >= bus.i_dn_th) && (cnt_q[ch] <= bus.i_up_th) &&
                   (cnt_q[ch] != CNT_MAX);
      evt_d[ch]  = run_end[ch] & in_win[ch] & ~cfg_err_q;
      adopt[ch]  = take[ch] && (cnt_d[ch] > bus.i_up_th);
    end
  end

  // Threshold sanity flag, one cycle behind the live thresholds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (bus.i_dn_th > bus.i_up_th);
    end
  end

  // Per-channel run state, filtered level, event strobe and sticky flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_vld_q  <= '0;
      last_data_q <= '0;
      flt_q       <= '0;
      flt_sig_q   <= '0;
      evt_q       <= '0;
      lvl_q       <= '0;
      sticky_q    <= '0;
      for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
        // output level trails the filter state by one register
        flt_sig_q[ch] <= flt_q[ch] ^ bus.i_rtmon[ch];
        if (bus.i_clr[ch]) begin
          last_vld_q[ch]  <= 1'b0;
          last_data_q[ch] <= 1'b0;
          cnt_q[ch]       <= '0;
          flt_q[ch]       <= 1'b0;
          evt_q[ch]       <= 1'b0;
          sticky_q[ch]    <= 1'b0;
        end else begin
          if (take[ch]) begin
            last_vld_q[ch]  <= 1'b1;
            last_data_q[ch] <= bus.i_vld_data[ch];
            cnt_q[ch]       <= cnt_d[ch];
            if (adopt[ch]) begin
              flt_q[ch] <= bus.i_vld_data[ch];
            end
          end
          evt_q[ch] <= evt_d[ch];
          if (evt_d[ch]) begin
            lvl_q[ch] <= last_data_q[ch];
          end
          // a new event outranks a simultaneous sticky clear
          if (evt_d[ch]) begin
            sticky_q[ch] <= 1'b1;
          end else if (bus.i_sticky_clr[ch]) begin
            sticky_q[ch] <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.o_flt_sig    = flt_sig_q;
  assign bus.o_pls_evt    = evt_q;
  assign bus.o_pls_lvl    = lvl_q;
  assign bus.o_pls_sticky = sticky_q;
  assign bus.o_cfg_err    = cfg_err_q;

`ifdef SIGNAL_FLT_MCH_GLITCH_CNT_EN
  logic [GCNT_W-1:0]        gcnt_q [CH_NUM];
  logic [CH_NUM-1:0]        short_run;
  logic [CH_NUM*GCNT_W-1:0] gcnt_flat;

  // Short-run detection and flattening of the glitch counters.
  always_comb begin
    short_run = '0;
    gcnt_flat = '0;
    for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
      short_run[ch] = run_end[ch] & (cnt_q[ch] < bus.i_dn_th) & ~cfg_err_q;
      gcnt_flat[ch*GCNT_W +: GCNT_W] = gcnt_q[ch];
    end
  end

  // Saturating glitch counters; a clear coinciding with a glitch leaves 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
        gcnt_q[ch] <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
        if (bus.i_clr[ch]) begin
          gcnt_q[ch] <= '0;
        end else if (bus.i_sticky_clr[ch]) begin
          gcnt_q[ch] <= short_run[ch] ? GCNT_W'(1) : '0;
        end else if (short_run[ch] && !(&gcnt_q[ch])) begin
          gcnt_q[ch] <= gcnt_q[ch] + GCNT_W'(1);
        end
      end
    end
  end

  assign bus.o_glitch_cnt = gcnt_flat;
`else
  assign bus.o_glitch_cnt = {(CH_NUM*GCNT_W){1'b0}};
`endif

endmodule
